// File: rtl/instr_decode_stage_pkg.sv
// Shared RV32I decode definitions: opcode constants, immediate kinds,
// skid-buffer states, the decoded beat record and the legality check.
package instr_decode_stage_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [6:0] OPC_R     = 7'b0110011;
   localparam logic [6:0] OPC_I     = 7'b0010011;
   localparam logic [6:0] OPC_L     = 7'b0000011;
   localparam logic [6:0] OPC_S     = 7'b0100011;
   localparam logic [6:0] OPC_B     = 7'b1100011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;
   localparam logic [6:0] OPC_JAL   = 7'b1101111;
   localparam logic [6:0] OPC_JALR  = 7'b1100111;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [2:0] {
      IMM_I    = 3'd0,
      IMM_S    = 3'd1,
      IMM_B    = 3'd2,
      IMM_U    = 3'd3,
      IMM_J    = 3'd4,
      IMM_NONE = 3'd5
   } imm_type_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } skid_state_e;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [2:0]  func3;
      logic [6:0]  func7;
      logic [31:0] pc;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [31:0] store_dat;
      logic [31:0] br_off;
      logic [4:0]  rd;
      logic        reg_write;
      logic        illegal;
   } dec_beat_t;

   // Flags encodings outside the supported RV32I base set.
   function automatic logic is_illegal(input logic [31:0] instr);
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
      logic       ill;
      opc = instr[6:0];
      f3  = instr[14:12];
      f7  = instr[31:25];
      ill = 1'b0;
      case (opc)
         OPC_R: begin
            if (f7 == 7'h00) begin
               ill = 1'b0;
            end else if (f7 == 7'h20) begin
               ill = !((f3 == 3'b000) || (f3 == 3'b101));
            end else begin
               ill = 1'b1;
            end
         end
         OPC_I: begin
            if (f3 == 3'b001) begin
               ill = (f7 != 7'h00);
            end else if (f3 == 3'b101) begin
               ill = !((f7 == 7'h00) || (f7 == 7'h20));
            end else begin
               ill = 1'b0;
            end
         end
         OPC_L:    ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
         OPC_S:    ill = (f3 > 3'd2);
         OPC_B:    ill = (f3 == 3'd2) || (f3 == 3'd3);
         OPC_JALR: ill = (f3 != 3'd0);
         OPC_LUI, OPC_AUIPC, OPC_JAL: ill = 1'b0;
         default:  ill = 1'b1;
      endcase
      return ill;
   endfunction

endpackage

// File: rtl/instr_decode_stage_imm_gen.sv
// Immediate generator: classifies the instruction format and builds the
// sign-extended (or upper) 32-bit immediate in byte units.
module instr_decode_stage_imm_gen
   import instr_decode_stage_pkg::*;
(
   input  logic [31:0] instr,
   output imm_type_e   imm_type,
   output logic [31:0] imm
);

   // Select the immediate format from the opcode and assemble its bits.
   always_comb begin
      imm_type = IMM_NONE;
      imm      = 32'd0;
      case (instr[6:0])
         OPC_I, OPC_L, OPC_JALR: begin
            imm_type = IMM_I;
            imm      = {{20{instr[31]}}, instr[31:20]};
         end
         OPC_S: begin
            imm_type = IMM_S;
            imm      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         end
         OPC_B: begin
            imm_type = IMM_B;
            imm      = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         end
         OPC_LUI, OPC_AUIPC: begin
            imm_type = IMM_U;
            imm      = {instr[31:12], 12'd0};
         end
         OPC_JAL: begin
            imm_type = IMM_J;
            imm      = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         end
         default: begin
            imm_type = IMM_NONE;
            imm      = 32'd0;
         end
      endcase
   end

endmodule

// File: rtl/instr_decode_stage.sv
// RV32I decode stage: combinational decode of the fetch beat, a two-entry
// skid buffer toward execute, flush handling and decode/illegal counters.
module instr_decode_stage
   import instr_decode_stage_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             if_valid,
   output logic             if_ready,
   input  logic [XLEN-1:0]  if_instr,
   input  logic [XLEN-1:0]  if_pc,
   input  logic             stall,
   input  logic             flush,
   output logic [4:0]       rf_rs1_addr,
   output logic [4:0]       rf_rs2_addr,
   input  logic [XLEN-1:0]  rf_rs1_data,
   input  logic [XLEN-1:0]  rf_rs2_data,
   output logic             ex_valid,
   input  logic             ex_ready,
   output logic [6:0]       ex_opcode,
   output logic [2:0]       ex_func3,
   output logic [6:0]       ex_func7,
   output logic [XLEN-1:0]  ex_pc,
   output logic [XLEN-1:0]  ex_operand1,
   output logic [XLEN-1:0]  ex_operand2,
   output logic [XLEN-1:0]  ex_store_dat,
   output logic [XLEN-1:0]  ex_br_off,
   output logic [4:0]       ex_rd,
   output logic             ex_reg_write,
   output logic             ex_illegal,
   output logic [CNT_W-1:0] dec_cnt,
   output logic [CNT_W-1:0] ill_cnt
);

   skid_state_e      state_r;
   dec_beat_t        out_r;
   dec_beat_t        skid_r;
   logic             ex_valid_r;
   logic [CNT_W-1:0] dec_cnt_r;
   logic [CNT_W-1:0] ill_cnt_r;

   dec_beat_t   dec_s;
   imm_type_e   imm_type_s;
   logic [31:0] imm_s;
   logic        ill_s;
   logic        wr_kind_s;
   logic        accept_s;
   logic        taken_s;
   logic [6:0]  opc_s;
   logic [2:0]  f3_s;

   instr_decode_stage_imm_gen u_imm_gen (
      .instr    (if_instr),
      .imm_type (imm_type_s),
      .imm      (imm_s)
   );

   assign rf_rs1_addr = if_instr[19:15];
   assign rf_rs2_addr = if_instr[24:20];
   assign opc_s       = if_instr[6:0];
   assign f3_s        = if_instr[14:12];
   assign ill_s       = is_illegal(if_instr);
   assign if_ready    = rst_n && (state_r != ST_FULL) && !stall;
   assign accept_s    = if_valid && if_ready;
   assign taken_s     = ex_valid_r && ex_ready;

   // Build the execute-ready record for the instruction currently on the fetch port.
   always_comb begin
      dec_s        = '0;
      wr_kind_s    = 1'b0;
      dec_s.opcode = opc_s;
      dec_s.func3  = f3_s;
      dec_s.pc     = if_pc;
      dec_s.rd     = if_instr[11:7];
      dec_s.op1    = rf_rs1_data;
      dec_s.op2    = 32'd0;
      case (opc_s)
         OPC_R: begin
            dec_s.func7 = if_instr[31:25];
            dec_s.op2   = rf_rs2_data;
            wr_kind_s   = 1'b1;
         end
         OPC_I: begin
            dec_s.func7 = if_instr[31:25];
            // Shifts hand the ALU a bare shift amount rather than the raw I-immediate.
            dec_s.op2   = ((f3_s == 3'b001) || (f3_s == 3'b101)) ? {27'd0, if_instr[24:20]} : imm_s;
            wr_kind_s   = 1'b1;
         end
         OPC_L, OPC_JALR: begin
            dec_s.op2 = imm_s;
            wr_kind_s = 1'b1;
         end
         OPC_S: begin
            dec_s.op2 = imm_s;
         end
         OPC_B: begin
            dec_s.op2 = rf_rs2_data;
         end
         OPC_JAL, OPC_LUI: begin
            dec_s.func3 = 3'd0;
            dec_s.op1   = 32'd0;
            dec_s.op2   = imm_s;
            wr_kind_s   = 1'b1;
         end
         OPC_AUIPC: begin
            dec_s.func3 = 3'd0;
            dec_s.op1   = if_pc;
            dec_s.op2   = imm_s;
            wr_kind_s   = 1'b1;
         end
         default: begin
            dec_s.op2 = 32'd0;
         end
      endcase
      if ((imm_type_s == IMM_B) || (imm_type_s == IMM_J)) begin
         dec_s.br_off = 32'($signed(imm_s) >>> 2);
      end else begin
         dec_s.br_off = 32'd0;
      end
      dec_s.store_dat = ((opc_s == OPC_S) && !ill_s) ? rf_rs2_data : 32'd0;
      dec_s.reg_write = wr_kind_s && (dec_s.rd != 5'd0) && !ill_s;
      dec_s.illegal   = ill_s;
   end

   // Skid-buffer FSM: output register plus one overflow entry, strict FIFO order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= ST_EMPTY;
         ex_valid_r <= 1'b0;
         out_r      <= '0;
         skid_r     <= '0;
      end else if (flush) begin
         state_r    <= ST_EMPTY;
         ex_valid_r <= 1'b0;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (accept_s) begin
                  out_r      <= dec_s;
                  ex_valid_r <= 1'b1;
                  state_r    <= ST_BUSY;
               end else begin
                  ex_valid_r <= 1'b0;
               end
            end
            ST_BUSY: begin
               if (taken_s && accept_s) begin
                  out_r <= dec_s;
               end else if (taken_s) begin
                  ex_valid_r <= 1'b0;
                  state_r    <= ST_EMPTY;
               end else if (accept_s) begin
                  skid_r  <= dec_s;
                  state_r <= ST_FULL;
               end else begin
                  state_r <= ST_BUSY;
               end
            end
            ST_FULL: begin
               if (taken_s) begin
                  out_r   <= skid_r;
                  state_r <= ST_BUSY;
               end else begin
                  state_r <= ST_FULL;
               end
            end
            default: begin
               state_r    <= ST_EMPTY;
               ex_valid_r <= 1'b0;
            end
         endcase
      end
   end

   // Count beats that survive acceptance, and the illegal ones among them.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dec_cnt_r <= '0;
         ill_cnt_r <= '0;
      end else if (accept_s && !flush) begin
         dec_cnt_r <= dec_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         if (dec_s.illegal) begin
            ill_cnt_r <= ill_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            ill_cnt_r <= ill_cnt_r;
         end
      end else begin
         dec_cnt_r <= dec_cnt_r;
         ill_cnt_r <= ill_cnt_r;
      end
   end

   assign ex_valid     = ex_valid_r;
   assign ex_opcode    = out_r.opcode;
   assign ex_func3     = out_r.func3;
   assign ex_func7     = out_r.func7;
   assign ex_pc        = out_r.pc;
   assign ex_operand1  = out_r.op1;
   assign ex_operand2  = out_r.op2;
   assign ex_store_dat = out_r.store_dat;
   assign ex_br_off    = out_r.br_off;
   assign ex_rd        = out_r.rd;
   assign ex_reg_write = out_r.reg_write;
   assign ex_illegal   = out_r.illegal;
   assign dec_cnt      = dec_cnt_r;
   assign ill_cnt      = ill_cnt_r;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Testbench for instr_decode_stage: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// queue-based reference model of the decode stage.
module tb_instr_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n, if_valid, if_ready, stall, flush, ex_valid, ex_ready;
   logic [31:0] if_instr, if_pc, rf_rs1_data, rf_rs2_data;
   logic [4:0]  rf_rs1_addr, rf_rs2_addr, ex_rd;
   logic [6:0]  ex_opcode, ex_func7;
   logic [2:0]  ex_func3;
   logic [31:0] ex_pc, ex_operand1, ex_operand2, ex_store_dat, ex_br_off, dec_cnt, ill_cnt;
   logic        ex_reg_write, ex_illegal;

   logic [31:0] rf [32];

   always #5 clk = ~clk;

   assign rf_rs1_data = rf[rf_rs1_addr];
   assign rf_rs2_data = rf[rf_rs2_addr];

   instr_decode_stage #(.XLEN(32), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
      .if_instr(if_instr), .if_pc(if_pc), .stall(stall), .flush(flush),
      .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
      .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode),
      .ex_func3(ex_func3), .ex_func7(ex_func7), .ex_pc(ex_pc),
      .ex_operand1(ex_operand1), .ex_operand2(ex_operand2),
      .ex_store_dat(ex_store_dat), .ex_br_off(ex_br_off), .ex_rd(ex_rd),
      .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal),
      .dec_cnt(dec_cnt), .ill_cnt(ill_cnt)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] pc, op1, op2, sd, br;
      logic [4:0]  rd;
      logic        rw, ill;
   } beat_t;

   beat_t       q[$];
   int unsigned m_dec = 0;
   int unsigned m_ill = 0;

   // Reference decode written from the instruction-set rules in plain arithmetic.
   function automatic beat_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
      beat_t       e;
      logic [6:0]  opc = ins[6:0];
      logic [2:0]  f3  = ins[14:12];
      logic [6:0]  f7  = ins[31:25];
      logic [31:0] a   = rf[ins[19:15]];
      logic [31:0] b   = rf[ins[24:20]];
      int immI, immS, immB, immJ;
      logic [31:0] immU;
      logic ill, wr;
      immI = int'(ins[30:20]) - (ins[31] ? 2048 : 0);
      immS = int'(ins[30:25]) * 32 + int'(ins[11:7]) - (ins[31] ? 2048 : 0);
      immB = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2 - (ins[31] ? 4096 : 0);
      immJ = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2 - (ins[31] ? 1048576 : 0);
      immU = ins & 32'hFFFF_F000;
      case (opc)
         7'h33: ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
         7'h13: ill = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && !(f7 == 7'h00 || f7 == 7'h20));
         7'h03: ill = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
         7'h23: ill = (f3 > 3'd2);
         7'h63: ill = (f3 == 3'd2 || f3 == 3'd3);
         7'h67: ill = (f3 != 3'd0);
         7'h37, 7'h17, 7'h6F: ill = 1'b0;
         default: ill = 1'b1;
      endcase
      wr = (opc == 7'h33 || opc == 7'h13 || opc == 7'h03 || opc == 7'h37 ||
            opc == 7'h17 || opc == 7'h6F || opc == 7'h67);
      e.opc = opc;
      e.f3  = (opc == 7'h37 || opc == 7'h17 || opc == 7'h6F) ? 3'd0 : f3;
      e.f7  = (opc == 7'h33 || opc == 7'h13) ? f7 : 7'd0;
      e.pc  = pc;
      e.op1 = (opc == 7'h17) ? pc : ((opc == 7'h37 || opc == 7'h6F) ? 32'd0 : a);
      case (opc)
         7'h33, 7'h63: e.op2 = b;
         7'h13:        e.op2 = (f3 == 3'd1 || f3 == 3'd5) ? 32'(ins[24:20]) : 32'(immI);
         7'h03, 7'h67: e.op2 = 32'(immI);
         7'h23:        e.op2 = 32'(immS);
         7'h6F:        e.op2 = 32'(immJ);
         7'h37, 7'h17: e.op2 = immU;
         default:      e.op2 = 32'd0;
      endcase
      e.sd  = (opc == 7'h23 && !ill) ? b : 32'd0;
      e.br  = (opc == 7'h63) ? 32'(immB >>> 2) : ((opc == 7'h6F) ? 32'(immJ >>> 2) : 32'd0);
      e.rd  = ins[11:7];
      e.rw  = wr && (ins[11:7] != 5'd0) && !ill;
      e.ill = ill;
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r = $urandom;
      logic [6:0]  opc;
      logic [6:0]  f7;
      case ($urandom_range(0, 10))
         0: opc = 7'h33;  1: opc = 7'h13;  2: opc = 7'h03;
         3: opc = 7'h23;  4: opc = 7'h63;  5: opc = 7'h37;
         6: opc = 7'h17;  7: opc = 7'h6F;  8: opc = 7'h67;
         default: opc = r[6:0];
      endcase
      case ($urandom_range(0, 3))
         0: f7 = 7'h00;
         1: f7 = 7'h20;
         default: f7 = r[31:25];
      endcase
      return {f7, r[24:7], opc};
   endfunction

   // Per-cycle compare against the model, then advance the model to the next edge.
   initial begin
      logic  mrdy;
      logic  acc, tak;
      beat_t e;
      @(posedge clk);
      forever begin
         @(negedge clk);
         mrdy = rst_n && (q.size() < 2) && !stall;
         chk("if_ready", 32'(if_ready), 32'(mrdy));
         chk("ex_valid", 32'(ex_valid), 32'(q.size() != 0));
         chk("rs1_addr", 32'(rf_rs1_addr), 32'(if_instr[19:15]));
         chk("rs2_addr", 32'(rf_rs2_addr), 32'(if_instr[24:20]));
         chk("dec_cnt", dec_cnt, m_dec);
         chk("ill_cnt", ill_cnt, m_ill);
         if (q.size() != 0) begin
            e = q[0];
            chk("opcode", 32'(ex_opcode), 32'(e.opc));
            chk("func3", 32'(ex_func3), 32'(e.f3));
            chk("func7", 32'(ex_func7), 32'(e.f7));
            chk("pc", ex_pc, e.pc);
            chk("operand1", ex_operand1, e.op1);
            chk("operand2", ex_operand2, e.op2);
            chk("store_dat", ex_store_dat, e.sd);
            chk("br_off", ex_br_off, e.br);
            chk("rd", 32'(ex_rd), 32'(e.rd));
            chk("reg_write", 32'(ex_reg_write), 32'(e.rw));
            chk("illegal", 32'(ex_illegal), 32'(e.ill));
         end
         acc = if_valid && mrdy;
         tak = (q.size() != 0) && ex_ready;
         if (!rst_n) begin
            q.delete();
            m_dec = 0;
            m_ill = 0;
         end else if (flush) begin
            q.delete();
         end else begin
            if (tak) void'(q.pop_front());
            if (acc) begin
               e = ref_decode(if_instr, if_pc);
               q.push_back(e);
               m_dec++;
               if (e.ill) m_ill++;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [31:0] ins, input logic [31:0] pc);
      if_valid = 1'b1;
      if_instr = ins;
      if_pc    = pc;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      rf[0] = 32'd0;
      rf[2] = 32'd10;
      rf[5] = 32'hCAFE_0005;
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0; ex_ready = 1'b1;
      beat(32'h0000_0013, 32'd0);

      // Reset held with if_valid asserted.
      for (int i = 0; i < 2; i++) begin
         step();
         chk("rst_if_ready", 32'(if_ready), 32'd0);
         chk("rst_ex_valid", 32'(ex_valid), 32'd0);
         chk("rst_dec_cnt", dec_cnt, 32'd0);
      end
      rst_n = 1'b1; if_valid = 1'b0;
      step();

      // addi / srai / sw with literal field expectations.
      beat(32'h0051_0093, 32'h100);
      step();
      chk("addi_opcode", 32'(ex_opcode), 32'h13);
      chk("addi_op1", ex_operand1, 32'd10);
      chk("addi_op2", ex_operand2, 32'd5);
      chk("addi_rd", 32'(ex_rd), 32'd1);
      chk("addi_rw", 32'(ex_reg_write), 32'd1);
      beat(32'h4072_5193, 32'h101);
      step();
      chk("srai_func7", 32'(ex_func7), 32'h20);
      chk("srai_op2", ex_operand2, 32'd7);
      chk("srai_func3", 32'(ex_func3), 32'd5);
      beat(32'hFE53_2E23, 32'h102);
      step();
      chk("sw_op2", ex_operand2, 32'hFFFF_FFFC);
      chk("sw_store", ex_store_dat, 32'hCAFE_0005);
      chk("sw_rw", 32'(ex_reg_write), 32'd0);
      if_valid = 1'b0;
      step();

      // Backpressure: third beat held off until execute drains.
      ex_ready = 1'b0;
      beat(32'h0020_83B3, 32'h200); step();
      beat(32'h4041_8433, 32'h201); step();
      chk("bp_if_ready", 32'(if_ready), 32'd0);
      beat(32'h0081_2483, 32'h202); step();
      ex_ready = 1'b1; step(); step();
      if_valid = 1'b0; step();
      chk("bp_dec_cnt", dec_cnt, 32'd6);
      chk("bp_drained", 32'(ex_valid), 32'd0);

      // Flush while FULL, then flush while BUSY with a beat accepted.
      ex_ready = 1'b0;
      beat(32'h0020_83B3, 32'h300); step();
      beat(32'h4041_8433, 32'h301); step();
      beat(32'h0081_2483, 32'h302); flush = 1'b1; step();
      chk("flush_full_valid", 32'(ex_valid), 32'd0);
      chk("flush_full_cnt", dec_cnt, 32'd8);
      flush = 1'b0; step();
      beat(32'h0020_83B3, 32'h303); flush = 1'b1; step();
      chk("flush_busy_valid", 32'(ex_valid), 32'd0);
      chk("flush_busy_cnt", dec_cnt, 32'd9);
      flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
      step();

      // Illegal word and LUI.
      beat(32'hFFFF_FFFF, 32'h400); step();
      chk("ill_flag", 32'(ex_illegal), 32'd1);
      chk("ill_rw", 32'(ex_reg_write), 32'd0);
      chk("ill_cnt", ill_cnt, 32'd1);
      beat(32'h1234_50B7, 32'h401); step();
      chk("lui_op2", ex_operand2, 32'h1234_5000);
      chk("lui_op1", ex_operand1, 32'd0);
      chk("lui_rw", 32'(ex_reg_write), 32'd1);
      if_valid = 1'b0; step();

      // Randomized traffic with stalls, flushes, backpressure and occasional reset.
      for (int i = 0; i < 4000; i++) begin
         rst_n    = ($urandom_range(0, 199) != 0);
         if_valid = ($urandom_range(0, 3) != 0);
         ex_ready = ($urandom_range(0, 3) != 0);
         stall    = ($urandom_range(0, 9) == 0);
         flush    = ($urandom_range(0, 29) == 0);
         if_instr = rand_instr();
         if_pc    = $urandom;
         step();
      end
      rst_n = 1'b1; if_valid = 1'b0; flush = 1'b0; stall = 1'b0;
      step(); step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
